// File: rtl/channel_data_reorder_buffer_core_pkg.sv
// Shared constants and types for the channel data reorder buffer.
package channel_data_reorder_buffer_core_pkg;

  // Packet framing words
  localparam logic [15:0] HEADER_WORD = 16'hDEAD;
  localparam logic [15:0] ENDER_WORD  = 16'hBEEF;

  // Packet / storage geometry
  localparam int WORDS_PER_PACKET = 128;
  localparam int WORDS_PER_LINE   = 16;
  localparam int LINES_PER_BANK   = 8;
  localparam int NUM_BANKS        = 2;

  localparam int WORD_W     = 16;
  localparam int LINE_W     = WORD_W * WORDS_PER_LINE;
  localparam int CNT_W      = $clog2(WORDS_PER_PACKET);
  localparam int SLOT_W     = $clog2(WORDS_PER_LINE);
  localparam int LINE_IDX_W = $clog2(LINES_PER_BANK);
  localparam int BANK_IDX_W = $clog2(NUM_BANKS);
  localparam int MEM_IDX_W  = BANK_IDX_W + LINE_IDX_W;

  localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(WORDS_PER_PACKET - 1);
  localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(LINES_PER_BANK - 1);

  // Write-side packet framing FSM
  typedef enum logic [1:0] {
    WR_IDLE,
    WR_CAPTURE,
    WR_DROP
  } wr_state_e;

  // Flat line index into the storage array: bank-major, line-minor
  function automatic logic [MEM_IDX_W-1:0] mem_idx(input logic [BANK_IDX_W-1:0] bank,
                                                   input logic [LINE_IDX_W-1:0] line);
    return {bank, line};
  endfunction

endpackage

// File: rtl/channel_data_reorder_buffer_core_sync_2ff.sv
// Parameterised-width two-flop synchroniser with synchronous active-low clear.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back capture stages into the destination clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/channel_data_reorder_buffer_core.sv
// Channel data reorder buffer: frames 16-bit channel words into 128-word
// packets, packs them into 256-bit lines across two ping-pong banks written
// on inclk, and hands complete packets out line by line on outclk.
module channel_data_reorder_buffer_core
  import channel_data_reorder_buffer_core_pkg::*;
(
  input  logic              inclk,
  input  logic              outclk,
  input  logic              rst_n,
  input  logic              FIFO_ready_mask,
  input  logic [WORD_W-1:0] FIFO_rd_data,
  output logic              FIFO_rd_request,
  output logic              BRAM_ready_mask,
  output logic [LINE_W-1:0] DRAM_wr_data,
  input  logic              BRAM_rd_request
);

  // ---------------------------------------------------------------------
  // Write side (inclk)
  // ---------------------------------------------------------------------
  wr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BANK_IDX_W-1:0] wr_bank_q, wr_bank_d;
  logic [NUM_BANKS-1:0]  full_tgl_q, full_tgl_d;
  logic                  fifo_rd_req_q, fifo_rd_req_d;
  logic [NUM_BANKS-1:0]  rel_tgl_in;
  logic [NUM_BANKS-1:0]  bank_free;
  logic                  wr_free;
  logic                  mem_we;
  logic [MEM_IDX_W-1:0]  mem_widx;
  logic [SLOT_W-1:0]     mem_wslot;

  // Storage: one 16-bit slot per word so a single word can be written per
  // cycle; a line reads out as 256 bits with slot 0 in the LSBs.
  logic [NUM_BANKS*LINES_PER_BANK-1:0][WORDS_PER_LINE-1:0][WORD_W-1:0] mem_q;

  // ---------------------------------------------------------------------
  // Read side (outclk)
  // ---------------------------------------------------------------------
  logic                  rrst_n;
  logic [NUM_BANKS-1:0]  full_tgl_out;
  logic [NUM_BANKS-1:0]  rel_tgl_q, rel_tgl_d;
  logic [NUM_BANKS-1:0]  rd_full;
  logic [BANK_IDX_W-1:0] rd_bank_q, rd_bank_d;
  logic [LINE_IDX_W-1:0] rd_line_q, rd_line_d;
  logic                  rd_ready_q, rd_ready_d;
  logic [LINE_W-1:0]     dout_q, dout_d;
  logic                  rd_acc;

  // ---------------------------------------------------------------------
  // Clock-domain crossings
  // ---------------------------------------------------------------------
  // Reset is brought into outclk through the same synchroniser depth as the
  // full toggles, so a full flag cleared by reset never reaches the read
  // side ahead of its reset. Reset must be held for a few cycles of both
  // clocks so both toggle views settle to zero together.
  sync_2ff #(.WIDTH(1)) u_rst_sync (
    .clk   (outclk),
    .rst_n (1'b1),
    .d     (rst_n),
    .q     (rrst_n)
  );

  // A bank is full from the read side's view while the write toggle and the
  // local release toggle differ.
  sync_2ff #(.WIDTH(NUM_BANKS)) u_full_sync (
    .clk   (outclk),
    .rst_n (rrst_n),
    .d     (full_tgl_q),
    .q     (full_tgl_out)
  );

  // Release toggles travel back so the writer knows a bank is reusable.
  sync_2ff #(.WIDTH(NUM_BANKS)) u_rel_sync (
    .clk   (inclk),
    .rst_n (rst_n),
    .d     (rel_tgl_q),
    .q     (rel_tgl_in)
  );

  // ---------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------
  assign bank_free = ~(full_tgl_q ^ rel_tgl_in);
  assign wr_free   = bank_free[wr_bank_q];
  assign mem_widx  = mem_idx(wr_bank_q, cnt_q[CNT_W-1 -: LINE_IDX_W]);
  assign mem_wslot = cnt_q[SLOT_W-1:0];

  // Next-state: header hunt, capture into the write bank, or drop a packet
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_bank_d  = wr_bank_q;
    full_tgl_d = full_tgl_q;
    mem_we     = 1'b0;
    // Only pull from upstream when there is somewhere for the data to go.
    fifo_rd_req_d = FIFO_ready_mask && ((state_q != WR_IDLE) || wr_free);

    case (state_q)
      WR_IDLE: begin
        if (FIFO_ready_mask && (FIFO_rd_data == HEADER_WORD)) begin
          cnt_d = CNT_W'(1);
          if (wr_free) begin
            mem_we  = 1'b1;   // header lands in slot 0 (cnt_q is 0 here)
            state_d = WR_CAPTURE;
          end else begin
            state_d = WR_DROP;
          end
        end
      end

      WR_CAPTURE: begin
        if (FIFO_ready_mask) begin
          mem_we = 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = WR_IDLE;
            // A bad ender leaves the bank free; the next packet overwrites it.
            if (FIFO_rd_data == ENDER_WORD) begin
              full_tgl_d[wr_bank_q] = ~full_tgl_q[wr_bank_q];
              wr_bank_d             = wr_bank_q + BANK_IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      WR_DROP: begin
        // The header already counted as word 0 of the dropped packet.
        if (FIFO_ready_mask) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = WR_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = WR_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Write-side state registers
  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      state_q       <= WR_IDLE;
      cnt_q         <= '0;
      wr_bank_q     <= '0;
      full_tgl_q    <= '0;
      fifo_rd_req_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_bank_q     <= wr_bank_d;
      full_tgl_q    <= full_tgl_d;
      fifo_rd_req_q <= fifo_rd_req_d;
    end
  end

  // Word write into storage; contents are never cleared, framing state is
  always_ff @(posedge inclk) begin
    if (mem_we) begin
      mem_q[mem_widx][mem_wslot] <= FIFO_rd_data;
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  assign rd_full = full_tgl_out ^ rel_tgl_q;
  assign rd_acc  = BRAM_rd_request && rd_ready_q;

  // Pop one line per accepted request; the last line releases the bank
  always_comb begin
    rd_bank_d  = rd_bank_q;
    rd_line_d  = rd_line_q;
    rel_tgl_d  = rel_tgl_q;
    dout_d     = dout_q;
    rd_ready_d = rd_full[rd_bank_q];

    if (rd_acc) begin
      // Bank contents are stable while it is marked full, so reading the
      // inclk-written array from outclk is safe here.
      dout_d = mem_q[mem_idx(rd_bank_q, rd_line_q)];
      if (rd_line_q == LAST_LINE) begin
        rd_line_d             = '0;
        rd_bank_d             = rd_bank_q + BANK_IDX_W'(1);
        rel_tgl_d[rd_bank_q]  = ~rel_tgl_q[rd_bank_q];
        rd_ready_d            = rd_full[rd_bank_d];
      end else begin
        rd_line_d = rd_line_q + LINE_IDX_W'(1);
      end
    end
  end

  // Read-side state registers
  always_ff @(posedge outclk) begin
    if (!rrst_n) begin
      rd_bank_q  <= '0;
      rd_line_q  <= '0;
      rel_tgl_q  <= '0;
      rd_ready_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      rd_bank_q  <= rd_bank_d;
      rd_line_q  <= rd_line_d;
      rel_tgl_q  <= rel_tgl_d;
      rd_ready_q <= rd_ready_d;
      dout_q     <= dout_d;
    end
  end

  assign FIFO_rd_request = fifo_rd_req_q;
  assign BRAM_ready_mask = rd_ready_q;
  assign DRAM_wr_data    = dout_q;

endmodule

// File: tb/tb_channel_data_reorder_buffer_core.sv
// Bench for the channel data reorder buffer: packet-level reference model
// (queue of expected packets, spec word->line mapping) against DUT lines.
module tb_channel_data_reorder_buffer_core;

  typedef logic [127:0][15:0] pkt_t;

  logic         inclk = 1'b0;
  logic         outclk = 1'b0;
  logic         rst_n;
  logic         FIFO_ready_mask;
  logic [15:0]  FIFO_rd_data;
  logic         FIFO_rd_request;
  logic         BRAM_ready_mask;
  logic [255:0] DRAM_wr_data;
  logic         BRAM_rd_request;

  int           n_tests = 0;
  int           n_fail  = 0;
  bit           rd_en   = 1'b0;
  bit           pend    = 1'b0;
  logic [255:0] rx_q[$];
  pkt_t         exp_q[$];
  int           rx_ptr    = 0;
  int           exp_lines = 0;
  logic [255:0] last_exp_line = '0;

  channel_data_reorder_buffer_core dut (
    .inclk           (inclk),
    .outclk          (outclk),
    .rst_n           (rst_n),
    .FIFO_ready_mask (FIFO_ready_mask),
    .FIFO_rd_data    (FIFO_rd_data),
    .FIFO_rd_request (FIFO_rd_request),
    .BRAM_ready_mask (BRAM_ready_mask),
    .DRAM_wr_data    (DRAM_wr_data),
    .BRAM_rd_request (BRAM_rd_request)
  );

  always #5 inclk  = ~inclk;
  always #4 outclk = ~outclk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference packet: header, timestamp, 125 payload words, ender
  function automatic pkt_t mk_pkt(input int iter, input bit rnd, input logic [15:0] ender);
    pkt_t p;
    p[0] = 16'hDEAD;
    p[1] = rnd ? 16'($urandom) : 16'hAAAA;
    for (int n = 0; n < 125; n++)
      p[n+2] = rnd ? 16'($urandom) : {8'(iter), 8'(n)};
    p[127] = ender;
    return p;
  endfunction

  // Line l of a packet: words 16l..16l+15, first word in the LSBs
  function automatic logic [255:0] model_line(input pkt_t p, input int l);
    logic [255:0] ln;
    for (int w = 0; w < 16; w++) ln[16*w +: 16] = p[16*l + w];
    return ln;
  endfunction

  function automatic logic [255:0] get_rx(input int i);
    return (i < rx_q.size()) ? rx_q[i] : {256{1'bx}};
  endfunction

  task automatic expect_pkt(input pkt_t p);
    exp_q.push_back(p);
    exp_lines += 8;
  endtask

  // Drive one packet (words up to stop_at-1), optional random stalls, then gap
  task automatic send_pkt(input pkt_t p, input bit stall, input int stop_at);
    for (int i = 0; i < 128; i++) begin
      if (i == stop_at) return;
      if (stall && ($urandom_range(0, 7) == 0)) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge inclk);
          FIFO_ready_mask = 1'b0;
          FIFO_rd_data    = 16'($urandom);
        end
      end
      @(negedge inclk);
      FIFO_ready_mask = 1'b1;
      FIFO_rd_data    = p[i];
    end
    @(negedge inclk);
    FIFO_ready_mask = 1'b0;
    FIFO_rd_data    = 16'h0000;
    repeat (21) @(negedge inclk);
  endtask

  // Wait (bounded) for all expected lines, then score them in order
  task automatic wait_drain(input string tag);
    for (int c = 0; c < 4000 && rx_q.size() < exp_lines; c++) @(negedge outclk);
    repeat (20) @(negedge outclk);
    check({tag, "_line_count"}, 256'(rx_q.size()), 256'(exp_lines));
    while (exp_q.size() > 0) begin
      pkt_t p;
      p = exp_q.pop_front();
      for (int l = 0; l < 8; l++) begin
        logic [255:0] exp_ln;
        exp_ln = model_line(p, l);
        check($sformatf("%s_rx%0d_line%0d", tag, rx_ptr, l), get_rx(rx_ptr), exp_ln);
        last_exp_line = exp_ln;
        rx_ptr++;
      end
    end
  endtask

  // Outclk reader: request whenever enabled, collect each accepted line
  initial begin
    BRAM_rd_request = 1'b0;
    forever begin
      @(negedge outclk);
      if (pend) rx_q.push_back(DRAM_wr_data);
      BRAM_rd_request = rd_en;
      pend = BRAM_rd_request && BRAM_ready_mask;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    pkt_t         p;
    logic [255:0] ln;
    int           n0;

    rst_n           = 1'b0;
    FIFO_ready_mask = 1'b0;
    FIFO_rd_data    = 16'h0000;
    repeat (3) @(negedge inclk);
    check("rst_fifo_rd_request", 256'(FIFO_rd_request), 256'(0));
    check("rst_bram_ready_mask", 256'(BRAM_ready_mask), 256'(0));
    check("rst_dram_wr_data", DRAM_wr_data, 256'(0));
    rst_n = 1'b1;
    rd_en = 1'b1;
    repeat (3) @(negedge inclk);

    // Read request is a registered copy of the mask while idle with a free bank
    FIFO_ready_mask = 1'b1;
    FIFO_rd_data    = 16'h0000;
    @(negedge inclk);
    check("rdreq_idle_free", 256'(FIFO_rd_request), 256'(1));
    FIFO_ready_mask = 1'b0;
    @(negedge inclk);
    check("rdreq_mask_low", 256'(FIFO_rd_request), 256'(0));

    // Ten-packet counting stream, stalls from packet 5 on
    for (int it = 0; it < 10; it++) begin
      p = mk_pkt(it, 1'b0, 16'hBEEF);
      expect_pkt(p);
      send_pkt(p, it >= 5, 128);
    end
    wait_drain("stream");
    ln = get_rx(0);
    check("p0_l0_header", 256'(ln[15:0]), 256'(16'hDEAD));
    check("p0_l0_timestamp", 256'(ln[31:16]), 256'(16'hAAAA));
    check("p0_l0_payload0", 256'(ln[47:32]), 256'(16'h0000));
    ln = get_rx(7);
    check("p0_l7_word112", 256'(ln[15:0]), 256'(16'h006E));
    check("p0_l7_ender", 256'(ln[255:240]), 256'(16'hBEEF));
    ln = get_rx(8);
    check("p1_l0_payload0", 256'(ln[47:32]), 256'(16'h0100));

    // Request kept high after ready falls: no movement
    n0 = rx_q.size();
    repeat (6) @(negedge outclk);
    check("ready_low_drained", 256'(BRAM_ready_mask), 256'(0));
    check("hold_dram_wr_data", DRAM_wr_data, last_exp_line);
    check("no_extra_pop", 256'(rx_q.size()), 256'(n0));

    // Corrupted ender: packet discarded, ready never rises for it
    p = mk_pkt(0, 1'b1, 16'h1234);
    send_pkt(p, 1'b1, 128);
    check("corrupt_ready_low", 256'(BRAM_ready_mask), 256'(0));
    check("corrupt_no_lines", 256'(rx_q.size()), 256'(exp_lines));
    p = mk_pkt(0, 1'b1, 16'hBEEF);
    expect_pkt(p);
    send_pkt(p, 1'b1, 128);
    wait_drain("after_corrupt");

    // Reads held off: two banks fill, third packet dropped
    rd_en = 1'b0;
    repeat (4) @(negedge outclk);
    p = mk_pkt(0, 1'b1, 16'hBEEF);
    expect_pkt(p);
    send_pkt(p, 1'b1, 128);
    check("ready_after_ender", 256'(BRAM_ready_mask), 256'(1));
    p = mk_pkt(0, 1'b1, 16'hBEEF);
    expect_pkt(p);
    send_pkt(p, 1'b0, 128);
    FIFO_ready_mask = 1'b1;
    FIFO_rd_data    = 16'h0000;
    @(negedge inclk);
    check("rdreq_idle_banks_full", 256'(FIFO_rd_request), 256'(0));
    FIFO_ready_mask = 1'b0;
    p = mk_pkt(0, 1'b1, 16'hBEEF);
    send_pkt(p, 1'b1, 128);
    check("blocked_no_lines", 256'(rx_q.size()), 256'(exp_lines - 16));
    rd_en = 1'b1;
    wait_drain("resume_p0p1");
    p = mk_pkt(0, 1'b1, 16'hBEEF);
    expect_pkt(p);
    send_pkt(p, 1'b1, 128);
    wait_drain("resume_p3");

    // Reset at payload word 60 (stream word 62)
    p = mk_pkt(0, 1'b1, 16'hBEEF);
    send_pkt(p, 1'b0, 63);
    @(negedge inclk);
    rst_n           = 1'b0;
    FIFO_ready_mask = 1'b1;
    FIFO_rd_data    = 16'h0000;
    repeat (4) @(negedge inclk);
    check("midrst_fifo_rd_request", 256'(FIFO_rd_request), 256'(0));
    check("midrst_bram_ready_mask", 256'(BRAM_ready_mask), 256'(0));
    check("midrst_dram_wr_data", DRAM_wr_data, 256'(0));
    FIFO_ready_mask = 1'b0;
    rst_n           = 1'b1;
    repeat (5) @(negedge inclk);
    p = mk_pkt(0, 1'b1, 16'hBEEF);
    expect_pkt(p);
    send_pkt(p, 1'b1, 128);
    wait_drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_data_reorder_buffer_core.md
CHANNEL_DATA_REORDER_BUFFER_CORE -- requirements
Module: channel_data_reorder_buffer

Interface
REQ-001 SHALL have: inclk  input  1  write-side clock; all inclk logic on rising edge.
REQ-002 SHALL have: outclk  input  1  read-side clock, asynchronous to inclk.
REQ-003 SHALL have: rst_n  input  1  reset, synchronous, active-low; clock inclk; also re-synchronised (2-flop) into outclk domain for read-side logic.
REQ-004 SHALL have: FIFO_ready_mask  input  1  upstream channel FIFO has data; stream words valid only while high.
REQ-005 SHALL have: FIFO_rd_data  input  16  channel data word, one per inclk cycle.
REQ-006 SHALL have: FIFO_rd_request  output  1  (inclk) read request to upstream FIFO.
REQ-007 SHALL have: BRAM_ready_mask  output  1  (outclk) at least one complete packet buffered.
REQ-008 SHALL have: DRAM_wr_data  output  256  (outclk) one buffer line, 16 words.
REQ-009 SHALL have: BRAM_rd_request  input  1  (outclk) pop one line.

Function
REQ-010 Packet format SHALL be 128 words: 0xDEAD header, timestamp, 125 payload words, 0xBEEF ender = exactly 8 lines of 256 bits.
REQ-011 Storage SHALL be two ping-pong banks, each 8 lines x 256 bits, written in inclk, read in outclk.
REQ-012 Write FSM states SHALL be IDLE, CAPTURE, DROP; reset state IDLE, word counter 0, write bank 0.
REQ-013 IDLE: word sampled with FIFO_ready_mask=1 and value 0xDEAD -> if write bank free, store as word 0, go CAPTURE; if not free, go DROP; other words ignored.
REQ-014 CAPTURE: every cycle with FIFO_ready_mask=1 stores next word; word n goes to line n/16, bits [16*(n%16)+15 : 16*(n%16)] (first word in LSBs); FIFO_ready_mask=0 stalls counter.
REQ-015 On word 127: if value 0xBEEF, bank marked full and write bank toggles; otherwise bank left free (packet discarded); either way -> IDLE.
REQ-016 DROP: count 128 valid words without storing, then IDLE.
REQ-017 FIFO_rd_request SHALL be registered: 1 when FIFO_ready_mask=1 and (FSM not IDLE or write bank free); 0 in reset.
REQ-018 Bank full flags SHALL cross to outclk via toggle + 2-flop synchronisers; release flags cross back likewise; BRAM_ready_mask high within 3 outclk cycles after the ender edge.
REQ-019 BRAM_ready_mask SHALL be registered, high iff the current read bank is full (outclk view).
REQ-020 A read SHALL be accepted only at an outclk edge where BRAM_rd_request=1 and BRAM_ready_mask=1; requests with ready low are ignored, no underflow.
REQ-021 Accepted read SHALL load DRAM_wr_data with the current line on that edge (1-cycle latency); DRAM_wr_data holds between reads.
REQ-022 The read accepting line 7 SHALL, on that same edge, clear BRAM_ready_mask (unless the other bank is already full), release the bank, toggle read bank, reset line pointer.
REQ-023 Banks SHALL be read in the order written; packets never interleave.
REQ-024 Bank released in outclk SHALL become writable within 3 inclk cycles; a header arriving earlier is dropped per REQ-013.

Reset
REQ-025 rst_n=0 SHALL clear: FSM IDLE, counters 0, both banks free, bank pointers 0, FIFO_rd_request 0, BRAM_ready_mask 0, DRAM_wr_data 0.
REQ-026 Reset mid-packet SHALL discard the partial packet; bank contents need not be cleared.

Structure
REQ-027 Shared package SHALL hold HEADER_WORD=16'hDEAD, ENDER_WORD=16'hBEEF, WORDS_PER_PACKET=128, WORDS_PER_LINE=16, LINES_PER_BANK=8, NUM_BANKS=2.
REQ-028 One sub-module, sync_2ff (parameterised-width 2-flop synchroniser), SHALL be used for all crossings.

Verification
REQ-029 Reset 12 ns, then stream DEAD, AAAA, {iter,0..124}, BEEF, 22 zero gap, repeating; outclk reads whenever ready -> packet 0 line 0 [15:0]=DEAD, [31:16]=AAAA, [47:32]=0x0000; line 7 [15:0]=0x006E, [255:240]=BEEF.
REQ-030 Same stream -> packet 1 line 0 [47:32]=0x0100; 8 lines per packet; no line duplicated or skipped over 10 packets.
REQ-031 Hold BRAM_rd_request=0 for 3 packets -> 2 banks full, third packet dropped, FIFO_rd_request 0 in IDLE; resume reads -> packets 0,1 then 3 delivered.
REQ-032 Corrupt ender to 0x1234 -> packet discarded, BRAM_ready_mask stays 0 for it.
REQ-033 BRAM_rd_request held high one cycle after ready falls -> DRAM_wr_data unchanged, no pointer movement.
REQ-034 Assert rst_n=0 at payload word 60 -> all outputs 0; next full packet delivered intact.
